// File: rtl/traffic_phase_controller.sv
// Traffic phase controller: rotates NUM_PHASES conflicting approaches through
// GREEN -> AMBER -> ALLRED, with per-phase pedestrian walk service and an
// optional protected-left phase for phase 0 (enabled by LEFT_TURN_PHASE_EN).
module traffic_phase_controller #(
  parameter int NUM_PHASES = 2,
  parameter int TICK_DIV   = 27000000,
  parameter int GREEN_S    = 10,
  parameter int AMBER_S    = 3,
  parameter int ALLRED_S   = 1,
  parameter int WALK_S     = 4,
  parameter int FLASH_S    = 4,
  parameter int LEFT_S     = 5
) (
  input  logic                  clk_27,
  input  logic                  reset,
  input  logic                  debug,
  input  logic [NUM_PHASES-1:0] walk_request,
  input  logic                  left_turn_request,
  output logic [NUM_PHASES-1:0] green,
  output logic [NUM_PHASES-1:0] amber,
  output logic [NUM_PHASES-1:0] red,
  output logic [NUM_PHASES-1:0] walk,
  output logic [NUM_PHASES-1:0] dont_walk,
  output logic                  left_arrow,
  output logic [NUM_PHASES-1:0] walk_waiting,
  output logic [1:0]            phase,
  output logic [1:0]            state
);

  localparam int PW = $clog2(TICK_DIV + 1);
  localparam int DW = 16;

  typedef enum logic [1:0] {
    ALLRED = 2'd0,
    GREEN  = 2'd1,
    AMBER  = 2'd2,
    LEFT   = 2'd3
  } state_t;

  state_t                state_q, state_nxt;
  logic [1:0]            phase_q, phase_nxt;
  logic [PW-1:0]         presc_q;
  logic [DW-1:0]         dur_q;
  logic [DW-1:0]         elapsed;
  logic                  tick;
  logic                  entry;
  logic                  served_q;
  logic                  left_pend;
  logic [NUM_PHASES-1:0] nxt_onehot;

  function automatic logic [DW-1:0] dur_of(input state_t s);
    case (s)
      GREEN:   dur_of = DW'(GREEN_S);
      AMBER:   dur_of = DW'(AMBER_S);
      LEFT:    dur_of = DW'(LEFT_S);
      default: dur_of = DW'(ALLRED_S);
    endcase
  endfunction

  assign tick    = debug || (presc_q == PW'(TICK_DIV - 1));
  assign elapsed = DW'(GREEN_S) - dur_q;
  assign state   = state_q;
  assign phase   = phase_q;

  // Next-state decode and lamp outputs from the current state.
  always_comb begin
    state_nxt  = state_q;
    phase_nxt  = phase_q;
    entry      = 1'b0;
    nxt_onehot = '0;
    green      = '0;
    amber      = '0;
    red        = '1;
    walk       = '0;
    dont_walk  = '1;
    if (tick && dur_q == DW'(1)) begin
      entry = 1'b1;
      case (state_q)
        GREEN:   state_nxt = AMBER;
        AMBER:   state_nxt = ALLRED;
        ALLRED: begin
          phase_nxt = (phase_q == 2'(NUM_PHASES - 1)) ? 2'd0 : phase_q + 2'd1;
          state_nxt = (phase_nxt == 2'd0 && left_pend) ? LEFT : GREEN;
        end
        default: state_nxt = GREEN;
      endcase
    end
    for (int i = 0; i < NUM_PHASES; i++) begin
      nxt_onehot[i] = (phase_nxt == 2'(i));
      green[i]      = (state_q == GREEN) && (phase_q == 2'(i));
      amber[i]      = (state_q == AMBER) && (phase_q == 2'(i));
      red[i]        = !(green[i] || amber[i]);
      if (green[i] && served_q) begin
        if (elapsed < DW'(WALK_S)) begin
          walk[i]      = 1'b1;
          dont_walk[i] = 1'b0;
        end else if (elapsed < DW'(WALK_S + FLASH_S)) begin
          // Flash starts lit on the first tick after walk, then alternates.
          dont_walk[i] = (elapsed[0] == 1'(WALK_S % 2));
        end
      end
    end
  end

  // State, phase, prescaler and duration counter; prescaler restarts on entry.
  always_ff @(posedge clk_27) begin
    if (reset) begin
      state_q <= ALLRED;
      phase_q <= 2'(NUM_PHASES - 1);
      dur_q   <= DW'(ALLRED_S);
      presc_q <= '0;
    end else begin
      state_q <= state_nxt;
      phase_q <= phase_nxt;
      if (entry) begin
        dur_q   <= dur_of(state_nxt);
        presc_q <= '0;
      end else if (tick) begin
        dur_q   <= dur_q - DW'(1);
        presc_q <= '0;
      end else begin
        presc_q <= presc_q + PW'(1);
      end
    end
  end

  // Walk latching; the decision to serve a phase is frozen at its GREEN entry.
  always_ff @(posedge clk_27) begin
    if (reset) begin
      walk_waiting <= '0;
      served_q     <= 1'b0;
    end else if (entry && state_nxt == GREEN) begin
      served_q     <= |((walk_waiting | walk_request) & nxt_onehot);
      walk_waiting <= (walk_waiting | walk_request) & ~nxt_onehot;
    end else begin
      walk_waiting <= walk_waiting | walk_request;
    end
  end

`ifdef LEFT_TURN_PHASE_EN
  // Pending protected-left request; consumed when LEFT is entered.
  always_ff @(posedge clk_27) begin
    if (reset) begin
      left_pend <= 1'b0;
    end else if (entry && state_nxt == LEFT) begin
      left_pend <= 1'b0;
    end else if (left_turn_request) begin
      left_pend <= 1'b1;
    end
  end

  assign left_arrow = (state_q == LEFT);
`else
  logic unused_left_req;
  assign unused_left_req = left_turn_request;
  assign left_pend       = 1'b0;
  assign left_arrow      = 1'b0;
`endif

endmodule

// File: tb/tb_traffic_phase_controller.sv
// Directed bench for traffic_phase_controller (NUM_PHASES=2, TICK_DIV=5).
module tb_traffic_phase_controller;
  logic       clk_27 = 1'b0;
  logic       reset = 1'b0;
  logic       debug = 1'b1;
  logic [1:0] walk_request = 2'b00;
  logic       left_turn_request = 1'b0;
  logic [1:0] green, amber, red, walk, dont_walk, walk_waiting, phase, state;
  logic       left_arrow;
  int         checks = 0;
  int         fails = 0;

  traffic_phase_controller #(.NUM_PHASES(2), .TICK_DIV(5)) dut (
    .clk_27(clk_27), .reset(reset), .debug(debug),
    .walk_request(walk_request), .left_turn_request(left_turn_request),
    .green(green), .amber(amber), .red(red), .walk(walk),
    .dont_walk(dont_walk), .left_arrow(left_arrow),
    .walk_waiting(walk_waiting), .phase(phase), .state(state)
  );

  always #5 clk_27 = ~clk_27;

  task automatic step();
    @(posedge clk_27);
    #1;
  endtask

  // One reset edge; afterwards the bench is at cycle t=0 (ALLRED, phase 1).
  task automatic do_reset();
    reset = 1'b1;
    walk_request = 2'b00;
    left_turn_request = 1'b0;
    step();
    reset = 1'b0;
  endtask

  // Expected {state, phase} at cycle t after reset, debug=1.
  function automatic logic [3:0] exp_sp(input int t);
    int u, v;
    logic [1:0] ph;
    if (t == 0) return {2'd0, 2'd1};
    u  = (t - 1) % 28;
    ph = 2'(u / 14);
    v  = u % 14;
    if (v < 10) return {2'd1, ph};
    if (v < 13) return {2'd2, ph};
    return {2'd0, ph};
  endfunction

  task automatic test_reset();
    debug = 1'b1;
    reset = 1'b1;
    walk_request = 2'b11;
    step();
    checks++; if (state !== 2'd0) begin fails++; $display("FAIL reset_state got %0d exp 0", state); end
    checks++; if (phase !== 2'd1) begin fails++; $display("FAIL reset_phase got %0d exp 1", phase); end
    checks++; if (red !== 2'b11) begin fails++; $display("FAIL reset_red got %b exp 11", red); end
    checks++; if (green !== 2'b00 || amber !== 2'b00) begin fails++; $display("FAIL reset_green_amber got %b/%b exp 00/00", green, amber); end
    checks++; if (walk !== 2'b00 || dont_walk !== 2'b11) begin fails++; $display("FAIL reset_ped got walk %b dw %b exp 00/11", walk, dont_walk); end
    checks++; if (walk_waiting !== 2'b00) begin fails++; $display("FAIL reset_drops_request got %b exp 00", walk_waiting); end
    checks++; if (left_arrow !== 1'b0) begin fails++; $display("FAIL reset_left got %b exp 0", left_arrow); end
    step();
    checks++; if (state !== 2'd0) begin fails++; $display("FAIL reset_held_state got %0d exp 0", state); end
    reset = 1'b0;
    walk_request = 2'b00;
  endtask

  task automatic test_sequence();
    logic [3:0] e;
    logic [1:0] eg, ea;
    do_reset();
    for (int t = 0; t <= 60; t++) begin
      e  = exp_sp(t);
      eg = (e[3:2] == 2'd1) ? (2'b01 << e[1:0]) : 2'b00;
      ea = (e[3:2] == 2'd2) ? (2'b01 << e[1:0]) : 2'b00;
      checks++; if ({state, phase} !== e) begin fails++; $display("FAIL seq_state_phase t=%0d got %0d/%0d exp %0d/%0d", t, state, phase, e[3:2], e[1:0]); end
      checks++; if (green !== eg || amber !== ea || red !== ~(eg | ea)) begin fails++; $display("FAIL seq_lamps t=%0d got g%b a%b r%b exp g%b a%b r%b", t, green, amber, red, eg, ea, ~(eg | ea)); end
      checks++; if (walk !== 2'b00 || dont_walk !== 2'b11) begin fails++; $display("FAIL seq_no_walk t=%0d got walk %b dw %b exp 00/11", t, walk, dont_walk); end
      step();
    end
  endtask

  task automatic test_walk_service();
    logic ew, ed, eq;
    do_reset();
    for (int t = 0; t <= 30; t++) begin
      eq = (t >= 4 && t < 15);
      ew = (t >= 15 && t <= 18);
      ed = ew ? 1'b0 : ((t >= 19 && t <= 22) ? ((t % 2) == 1) : 1'b1);
      checks++; if (walk_waiting[1] !== eq) begin fails++; $display("FAIL walk1_waiting t=%0d got %b exp %b", t, walk_waiting[1], eq); end
      checks++; if (walk[1] !== ew || dont_walk[1] !== ed) begin fails++; $display("FAIL walk1_lamps t=%0d got w%b dw%b exp w%b dw%b", t, walk[1], dont_walk[1], ew, ed); end
      checks++; if (walk[0] !== 1'b0 || dont_walk[0] !== 1'b1) begin fails++; $display("FAIL walk0_idle t=%0d got w%b dw%b exp w0 dw1", t, walk[0], dont_walk[0]); end
      walk_request = (t == 3) ? 2'b10 : 2'b00;
      step();
    end
    walk_request = 2'b00;
  endtask

  task automatic test_late_request();
    logic ew0, eq0, ew1, eq1;
    do_reset();
    for (int t = 0; t <= 45; t++) begin
      ew0 = (t >= 29 && t <= 32);
      eq0 = (t >= 4 && t < 29);
      ew1 = (t >= 15 && t <= 18) || (t >= 43);
      eq1 = (t >= 17 && t < 43);
      checks++; if (walk[0] !== ew0) begin fails++; $display("FAIL late_walk0 t=%0d got %b exp %b", t, walk[0], ew0); end
      checks++; if (walk_waiting[0] !== eq0) begin fails++; $display("FAIL late_waiting0 t=%0d got %b exp %b", t, walk_waiting[0], eq0); end
      checks++; if (walk[1] !== ew1) begin fails++; $display("FAIL entry_walk1 t=%0d got %b exp %b", t, walk[1], ew1); end
      checks++; if (walk_waiting[1] !== eq1) begin fails++; $display("FAIL entry_waiting1 t=%0d got %b exp %b", t, walk_waiting[1], eq1); end
      case (t)
        3:       walk_request = 2'b01;
        14, 16:  walk_request = 2'b10;
        default: walk_request = 2'b00;
      endcase
      step();
    end
    walk_request = 2'b00;
  endtask

  task automatic test_reset_mid_walk();
    do_reset();
    for (int t = 0; t < 16; t++) begin
      walk_request = (t == 2) ? 2'b10 : ((t == 5) ? 2'b01 : 2'b00);
      step();
    end
    walk_request = 2'b00;
    checks++; if (walk[1] !== 1'b1 || walk_waiting !== 2'b01) begin fails++; $display("FAIL midwalk_setup got w%b q%b exp w1 q01", walk[1], walk_waiting); end
    reset = 1'b1;
    walk_request = 2'b11;
    step();
    checks++; if (state !== 2'd0 || phase !== 2'd1) begin fails++; $display("FAIL midwalk_reset_sp got %0d/%0d exp 0/1", state, phase); end
    checks++; if (red !== 2'b11 || walk !== 2'b00 || dont_walk !== 2'b11) begin fails++; $display("FAIL midwalk_reset_lamps got r%b w%b dw%b exp 11/00/11", red, walk, dont_walk); end
    checks++; if (walk_waiting !== 2'b00) begin fails++; $display("FAIL midwalk_reset_waiting got %b exp 00", walk_waiting); end
    reset = 1'b0;
    walk_request = 2'b00;
    step();
    checks++; if (state !== 2'd1 || phase !== 2'd0) begin fails++; $display("FAIL midwalk_restart got %0d/%0d exp 1/0", state, phase); end
    checks++; if (walk[0] !== 1'b0) begin fails++; $display("FAIL midwalk_no_walk0 got %b exp 0", walk[0]); end
  endtask

  task automatic test_tick_div();
    int n;
    debug = 1'b0;
    do_reset();
    n = 0;
    while (state == 2'd0 && n < 100) begin n++; step(); end
    checks++; if (n !== 5) begin fails++; $display("FAIL div_allred_cycles got %0d exp 5", n); end
    n = 0;
    while (green[0] === 1'b1 && n < 200) begin n++; step(); end
    checks++; if (n !== 50) begin fails++; $display("FAIL div_green_cycles got %0d exp 50", n); end
    n = 0;
    while (amber[0] === 1'b1 && n < 200) begin n++; step(); end
    checks++; if (n !== 15) begin fails++; $display("FAIL div_amber_cycles got %0d exp 15", n); end
    debug = 1'b1;
  endtask

  task automatic test_left_turn();
    do_reset();
    for (int t = 0; t <= 45; t++) begin
`ifdef LEFT_TURN_PHASE_EN
      if (t >= 29 && t <= 33) begin
        checks++; if (state !== 2'd3 || phase !== 2'd0 || left_arrow !== 1'b1 || red !== 2'b11) begin fails++; $display("FAIL left_phase t=%0d got s%0d p%0d la%b r%b exp s3 p0 la1 r11", t, state, phase, left_arrow, red); end
      end else if (t >= 34 && t <= 43) begin
        checks++; if (state !== 2'd1 || green !== 2'b01 || left_arrow !== 1'b0) begin fails++; $display("FAIL left_then_green t=%0d got s%0d g%b la%b exp s1 g01 la0", t, state, green, left_arrow); end
      end else if (t < 29) begin
        checks++; if (left_arrow !== 1'b0 || state === 2'd3) begin fails++; $display("FAIL left_early t=%0d got s%0d la%b exp no LEFT", t, state, left_arrow); end
      end
`else
      checks++; if (left_arrow !== 1'b0 || state === 2'd3) begin fails++; $display("FAIL left_disabled t=%0d got s%0d la%b exp la0 no LEFT", t, state, left_arrow); end
      if (t == 29) begin
        checks++; if (state !== 2'd1 || phase !== 2'd0) begin fails++; $display("FAIL left_disabled_green got %0d/%0d exp 1/0", state, phase); end
      end
`endif
      left_turn_request = (t == 16);
      step();
    end
    left_turn_request = 1'b0;
  endtask

  initial begin
    test_reset();
    test_sequence();
    test_walk_service();
    test_late_request();
    test_reset_mid_walk();
    test_tick_div();
    test_left_turn();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/traffic_phase_controller.md
TRAFFIC_PHASE_CONTROLLER -- requirements
Module: traffic_phase_controller

Interface
REQ-001 Parameter NUM_PHASES, default 2, number of conflicting approach phases served in rotation; legal range 2..4.
REQ-002 Parameter TICK_DIV, default 27000000, clk_27 cycles per one-second tick.
REQ-003 Parameters GREEN_S=10, AMBER_S=3, ALLRED_S=1, WALK_S=4, FLASH_S=4, LEFT_S=5, state durations in ticks; legal only if WALK_S+FLASH_S <= GREEN_S and every duration is >= 1.
REQ-004 clk_27  in  1  sole clock; all logic is rising-edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 debug  in  1  high: one tick per clock cycle instead of one per TICK_DIV cycles.
REQ-007 walk_request  in  NUM_PHASES  per-phase pedestrian request; active-high and already synchronised; a one-cycle pulse suffices.
REQ-008 left_turn_request  in  1  protected-left request for phase 0; active-high pulse.
REQ-009 green, amber, red  out  NUM_PHASES each  vehicle lamps per phase.
REQ-010 walk, dont_walk  out  NUM_PHASES each  pedestrian lamps per phase.
REQ-011 left_arrow  out  1  protected-left arrow for phase 0.
REQ-012 walk_waiting  out  NUM_PHASES  latched pending walk requests.
REQ-013 phase  out  2  index of the current phase.
REQ-014 state  out  2  current state: 0=ALLRED, 1=GREEN, 2=AMBER, 3=LEFT.

Function
REQ-015 The prescaler shall count clk_27 cycles and emit a tick every TICK_DIV cycles, or every cycle when debug=1; it shall restart on every state entry so that each state lasts exactly its duration in ticks.
REQ-016 The duration counter shall load the state duration on state entry and decrement on each tick; the state shall change on the clock edge of the tick that takes the count from 1 to 0.
REQ-017 State sequence per phase p: GREEN(GREEN_S) -> AMBER(AMBER_S) -> ALLRED(ALLRED_S) -> GREEN of phase (p+1) mod NUM_PHASES.
REQ-018 In GREEN only green[p] shall be high; in AMBER only amber[p] shall be high; every other phase, and phase p in ALLRED, shall show red only.
REQ-019 Exactly one of green/amber/red per phase shall be high in every cycle.
REQ-020 walk_waiting[i] shall set on walk_request[i] and hold until phase i enters GREEN, where it shall clear.
REQ-021 A phase entering GREEN with walk_waiting[i] set, or with walk_request[i] high on the entry edge, shall assert walk[i] for WALK_S ticks and then toggle dont_walk[i] every tick for FLASH_S ticks; it shall show solid dont_walk[i] for the rest of the phase.
REQ-022 A walk_request[i] arriving while phase i is GREEN, after the entry edge, shall be latched for the next service of phase i and shall not extend the current walk.
REQ-023 Exactly one of walk[i]/dont_walk[i] shall be high except during flash-low cycles, when both shall be low; the walk lamp of a phase that is not GREEN shall be dont_walk.
REQ-024 The phase counter shall wrap from NUM_PHASES-1 to 0.

Reset
REQ-025 While reset=1 at an edge: state=ALLRED, phase=NUM_PHASES-1, all red=1, all dont_walk=1, green, amber, walk, left_arrow and walk_waiting =0, prescaler and duration counter reloaded.
REQ-026 reset shall take priority over every other input, including mid-state and mid-walk; a walk_request on the same edge as reset shall be dropped.
REQ-027 After reset is released, the first transition shall be ALLRED -> phase 0 (or LEFT when enabled and pending) after ALLRED_S ticks.

Configuration
REQ-028 With macro LEFT_TURN_PHASE_EN defined, left_turn_request shall set a pending flag; an ALLRED -> phase 0 transition with the flag set shall enter LEFT for LEFT_S ticks, then GREEN of phase 0, and the flag shall clear on LEFT entry.
REQ-029 In LEFT, left_arrow=1 and red[0]=1; all other phases shall be red.
REQ-030 Without LEFT_TURN_PHASE_EN, left_turn_request shall be ignored, left_arrow shall be constant 0, and state 3 shall be unreachable.

Verification
REQ-031 NUM_PHASES=2, debug=1, reset 1 cycle -> ALLRED 1 cycle, green[0] 10 cycles, amber[0] 3, ALLRED 1, green[1] 10; repeat period 28 cycles.
REQ-032 walk_request[1] pulse during phase-0 GREEN -> walk_waiting[1]=1 until phase-1 entry, then walk[1] 4 cycles, dont_walk[1] toggling 4 cycles, solid dont_walk[1] 2 cycles.
REQ-033 walk_request[0] in cycle 3 of phase-0 GREEN -> no walk[0] that phase; walk[0] on the next phase-0 GREEN.
REQ-034 debug=0, TICK_DIV=5 -> green[0] lasts exactly 50 cycles.
REQ-035 reset asserted during walk[1] -> next edge all red, walk_waiting=0, phase=1, state=0.
REQ-036 LEFT_TURN_PHASE_EN, left_turn_request during phase-1 GREEN -> LEFT 5 cycles with left_arrow=1, then green[0]; without the macro, left_arrow stays 0.
